// File: rtl/sminadd_pkg.sv
// Shared types for the bit-serial minuend reconstruction adder.
package sminadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit combinational full adder used as the serial add cell.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_minuend_adder.sv
// Bit-serial A = D + B, LSB first, one bit per clock through a single full-adder cell.
module serial_minuend_adder
  import sminadd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] diff_in,
  input  logic [WIDTH-1:0] subt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  // Handshake: start is taken only when not busy (IDLE or DONE); the operands
  // are captured on that edge. busy stays high for exactly WIDTH cycles, then
  // done pulses for one cycle with sum_out/carry_out already valid.

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   s_sr;
  logic               carry_ff;
  logic               s_bit;
  logic               c_bit;
  logic [WIDTH-1:0]   s_shifted;

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_ff),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign s_shifted = {s_bit, s_sr[WIDTH-1:1]};
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry_ff  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr     <= diff_in;
            b_sr     <= subt_in;
            s_sr     <= '0;
            carry_ff <= 1'b0;
            cnt      <= '0;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          s_sr     <= s_shifted;
          carry_ff <= c_bit;
          cnt      <= cnt + CNT_W'(1);
          // Results are published on the same edge that enters DONE.
          if (cnt == LAST) begin
            sum_out   <= s_shifted;
            carry_out <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_minuend_adder.sv
// Directed and randomized checks of serial_minuend_adder against D + B arithmetic.
module tb_serial_minuend_adder;

  localparam int WIDTH = 8;
  localparam int TMO   = 40;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] diff_in;
  logic [WIDTH-1:0] subt_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;

  int tests;
  int fails;
  logic [WIDTH:0] exp_q[$];

  serial_minuend_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .diff_in   (diff_in),
    .subt_in   (subt_in),
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the (WIDTH+1)-bit true sum.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] b);
    return {1'b0, d} + {1'b0, b};
  endfunction

  // Waits from just after the accepting edge until done is seen at a negedge.
  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (n < TMO) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (busy) nb++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"}, 32'(sum_out), 32'(e[WIDTH-1:0]));
      check({tag, "_carry"}, 32'(carry_out), 32'(e[WIDTH]));
    end
  endtask

  // Drive at a negedge; the following posedge accepts.
  task automatic drive_start(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] b);
    diff_in = d;
    subt_in = b;
    start   = 1'b1;
    exp_q.push_back(model(d, b));
  endtask

  initial begin
    int n;
    int nb;
    int dones;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] rb;

    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    diff_in = '0;
    subt_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 5 + 3, with latency and busy length
    drive_start(8'h05, 8'h03);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(n, nb);
    n = n + 1;
    check("latency", 32'(n), 32'(WIDTH + 1));
    check("busy_cycles", 32'(nb + 1), 32'(WIDTH));
    check_result("add_5_3");
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("sum_holds", 32'(sum_out), 32'h08);

    // overflow and zero
    drive_start(8'hFF, 8'h01);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    check("done_seen_ff", 32'(done), 32'd1);
    check_result("add_ff_01");
    @(negedge clk);
    drive_start(8'h00, 8'h00);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    check("done_seen_00", 32'(done), 32'd1);
    check_result("add_00_00");
    @(negedge clk);

    // start held through RUN, inputs changed: no resample, relaunch from DONE
    drive_start(8'h3C, 8'h11);
    @(negedge clk);
    diff_in = 8'hAA;
    subt_in = 8'h55;
    @(negedge clk);
    check("sum_stable_in_run", 32'(sum_out), 32'h00);
    wait_done(n, nb);
    n = n + 2;
    check("held_latency", 32'(n), 32'(WIDTH + 1));
    check_result("held_first");
    exp_q.push_back(model(8'hAA, 8'h55));
    @(negedge clk);
    start = 1'b0;
    check("relaunch_busy", 32'(busy), 32'd1);
    wait_done(n, nb);
    n = n + 1;
    check("relaunch_latency", 32'(n), 32'(WIDTH + 1));
    check_result("held_second");
    @(negedge clk);

    // reset mid-RUN
    drive_start(8'h80, 8'h80);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum_out), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    drive_start(8'h80, 8'h80);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    check("done_seen_80", 32'(done), 32'd1);
    check_result("add_80_80");
    @(negedge clk);

    // randomized back-to-back sweep
    dones = 0;
    rd = 8'($urandom);
    rb = 8'($urandom);
    drive_start(rd, rb);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      diff_in = 8'($urandom);
      subt_in = 8'($urandom);
      wait_done(n, nb);
      n = n + 1;
      check("sweep_period", 32'(n), 32'(WIDTH + 1));
      if (done) dones++;
      check_result("sweep");
      if (i < 199) begin
        rd = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        drive_start(rd, rb);
      end else begin
        start = 1'b0;
      end
    end
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("sweep_done_count", 32'(dones), 32'd200);
    check("sweep_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
